// File: rtl/ucontrol_pkg.sv
// Shared definitions for the microprogrammed control unit: FSM states,
// ALU operation codes, bus mux/load codes and IR field constants.
package ucontrol_pkg;

    typedef enum logic [2:0] {
        ST_RST         = 3'd0,
        ST_FETCH       = 3'd1,
        ST_DECODE      = 3'd2,
        ST_ALU         = 3'd3,
        ST_BRANCH_EVAL = 3'd4,
        ST_BRANCH      = 3'd5,
        ST_PCINC       = 3'd6,
        ST_HALT        = 3'd7
    } state_t;

    // ALU operation codes; codes 0..4 with bit3 set take B = sext(B[12:0])
    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_XOR     = 4'd4;
    localparam logic [3:0] ALU_PASS_A  = 4'd5;
    localparam logic [3:0] ALU_INC4_A  = 4'd6;
    localparam logic [3:0] ALU_BR_DISP = 4'd7;
    localparam logic [3:0] ALU_IMM_BIT = 4'b1000;

    // Bus A/B mux codes
    localparam logic [5:0] MUX_IDLE = 6'd0;
    localparam logic [5:0] MUX_R0   = 6'd1;
    localparam logic [5:0] MUX_PC   = 6'd6;
    localparam logic [5:0] MUX_IR   = 6'd7;

    // Bus C load codes
    localparam logic [5:0] LD_PC   = 6'd5;
    localparam logic [5:0] LD_IR   = 6'd6;
    localparam logic [5:0] LD_NONE = 6'd15;

    // Clear decoder idle code
    localparam logic [3:0] CLR_IDLE = 4'hF;

    // IR field constants
    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [2:0] OP2_BICC  = 3'b010;

    localparam logic [3:0] OP3_ADD = 4'd0;
    localparam logic [3:0] OP3_AND = 4'd1;
    localparam logic [3:0] OP3_OR  = 4'd2;
    localparam logic [3:0] OP3_XOR = 4'd3;
    localparam logic [3:0] OP3_SUB = 4'd4;

    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BNE  = 4'b1001;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BVS  = 4'b0111;

    // Architectural register 0..3 -> bus A/B mux code (R0 = 1)
    function automatic logic [5:0] src_code(input logic [1:0] r);
        return {4'b0000, r} + MUX_R0;
    endfunction

    // op3[3:0] -> ALU operation (caller has already checked legality)
    function automatic logic [3:0] alu_from_op3(input logic [3:0] op3_lo);
        case (op3_lo)
            OP3_ADD: return ALU_ADD;
            OP3_SUB: return ALU_SUB;
            OP3_AND: return ALU_AND;
            OP3_OR:  return ALU_OR;
            OP3_XOR: return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ucontrol_sequencer_branch_cond_eval.sv
// Branch condition evaluator: decides taken/legal for a Bicc cond field
// against the latched PSR flags {n,z,v,c}.
module branch_cond_eval
    import ucontrol_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_psr,
    output logic       o_taken,
    output logic       o_legal
);

    logic w_n, w_z, w_v, w_c;
    assign w_n = i_psr[3];
    assign w_z = i_psr[2];
    assign w_v = i_psr[1];
    assign w_c = i_psr[0];

    // Map each supported condition to its flag test; anything else is illegal
    always_comb begin
        o_taken = 1'b0;
        o_legal = 1'b1;
        case (i_cond)
            COND_BA:   o_taken = 1'b1;
            COND_BE:   o_taken = w_z;
            COND_BNE:  o_taken = ~w_z;
            COND_BNEG: o_taken = w_n;
            COND_BCS:  o_taken = w_c;
            COND_BVS:  o_taken = w_v;
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ucontrol_sequencer.sv
// Microprogrammed control unit: fetches an instruction over a req/ack
// handshake, decodes the SPARC-style IR and sequences ALU, branch and
// PC-increment steps, driving the datapath bus/load/ALU controls.
//
// Handshake: mem_req is held high for the whole FETCH state; the cycle in
// which mem_ack is high is the transfer cycle (memory data is on BUS_C and
// the IR loads at the closing edge). Once raised, mem_req stays high until
// that transfer; ack seen in any other state is ignored.
module ucontrol_sequencer
    import ucontrol_pkg::*;
#(
    parameter int DATAWIDTH_BUS               = 32,
    parameter int DATAWIDTH_ALU_SELECTION     = 4,
    parameter int DATAWIDTH_DECODER_SELECTION = 4,
    parameter int DATA_BUS_CONTROL            = 6
)(
    input  logic                                   uCONTROL_CLOCK_50,
    input  logic                                   uCONTROL_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0]               uCONTROL_Registro_IR_InBUS,
    input  logic                                   uCONTROL_overflow_InLow,
    input  logic                                   uCONTROL_carry_InLow,
    input  logic                                   uCONTROL_negative_InLow,
    input  logic                                   uCONTROL_zero_InLow,
    input  logic                                   uCONTROL_mem_ack_InHigh,
    output logic                                   uCONTROL_mem_req_OutHigh,
    output logic                                   uCONTROL_busC_src_Out,
    output logic [DATA_BUS_CONTROL-1:0]            uCONTROL_BUS_CONTROL_A_OutBUS,
    output logic [DATA_BUS_CONTROL-1:0]            uCONTROL_BUS_CONTROL_B_OutBUS,
    output logic [DATA_BUS_CONTROL-1:0]            uCONTROL_BUS_CONTROL_C_OutBUS,
    output logic                                   uCONTROL_BUS_SELECTOR_A_Out,
    output logic                                   uCONTROL_BUS_SELECTOR_B_Out,
    output logic                                   uCONTROL_BUS_SELECTOR_C_Out,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_decoderclearselection_OutBUS,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     uCONTROL_aluselection_OutBUS,
    output logic [3:0]                             uCONTROL_psr_OutBUS,
    output logic                                   uCONTROL_halt_OutHigh,
    output logic [2:0]                             uCONTROL_state_OutBUS
);

    state_t     r_state;
    logic [5:0] r_bus_a;
    logic [5:0] r_bus_b;
    logic [5:0] r_bus_c;
    logic [3:0] r_alu;
    logic       r_mem_req;
    logic       r_busc_src;
    logic [3:0] r_psr;
    logic       r_halt;
    logic [3:0] r_cond;
    logic       r_setcc;

    // IR field extraction (valid while in DECODE, after the IR load edge)
    logic [1:0] w_op;
    logic [4:0] w_rd;
    logic [5:0] w_op3;
    logic [4:0] w_rs1;
    logic       w_i;
    logic [4:0] w_rs2;
    logic [2:0] w_op2;
    logic       w_unused;

    assign w_op  = uCONTROL_Registro_IR_InBUS[31:30];
    assign w_rd  = uCONTROL_Registro_IR_InBUS[29:25];
    assign w_op3 = uCONTROL_Registro_IR_InBUS[24:19];
    assign w_rs1 = uCONTROL_Registro_IR_InBUS[18:14];
    assign w_i   = uCONTROL_Registro_IR_InBUS[13];
    assign w_rs2 = uCONTROL_Registro_IR_InBUS[4:0];
    assign w_op2 = uCONTROL_Registro_IR_InBUS[24:22];
    // simm13 middle bits are consumed by the ALU path, not by the sequencer
    assign w_unused = &{1'b0, uCONTROL_Registro_IR_InBUS[12:5]};

    // Decode classification
    logic w_regs_ok;
    logic w_is_alu;
    logic w_is_branch;

    assign w_regs_ok   = (w_rd < 5'd4) && (w_rs1 < 5'd4) && (w_i || (w_rs2 < 5'd4));
    assign w_is_alu    = (w_op == OP_ARITH) && (w_op3[3:0] <= OP3_SUB) && w_regs_ok;
    assign w_is_branch = (w_op == OP_BRANCH) && (w_op2 == OP2_BICC);

    // Branch condition evaluation against latched flags
    logic w_taken;
    logic w_legal;

    branch_cond_eval u_branch_cond_eval (
        .i_cond  (r_cond),
        .i_psr   (r_psr),
        .o_taken (w_taken),
        .o_legal (w_legal)
    );

    // Sequencer FSM: next state and registered control word for that state
    always_ff @(posedge uCONTROL_CLOCK_50 or negedge uCONTROL_RESET_InLow) begin
        if (!uCONTROL_RESET_InLow) begin
            r_state    <= ST_RST;
            r_bus_a    <= MUX_IDLE;
            r_bus_b    <= MUX_IDLE;
            r_bus_c    <= LD_NONE;
            r_alu      <= ALU_ADD;
            r_mem_req  <= 1'b0;
            r_busc_src <= 1'b0;
            r_psr      <= 4'b0000;
            r_halt     <= 1'b0;
            r_cond     <= 4'b0000;
            r_setcc    <= 1'b0;
        end else begin
            // Idle control word unless the target state overrides it
            r_bus_a    <= MUX_IDLE;
            r_bus_b    <= MUX_IDLE;
            r_bus_c    <= LD_NONE;
            r_alu      <= ALU_ADD;
            r_mem_req  <= 1'b0;
            r_busc_src <= 1'b0;
            case (r_state)
                ST_RST: begin
                    r_state    <= ST_FETCH;
                    r_bus_a    <= MUX_PC;
                    r_mem_req  <= 1'b1;
                    r_busc_src <= 1'b1;
                end
                ST_FETCH: begin
                    if (uCONTROL_mem_ack_InHigh) begin
                        r_state <= ST_DECODE;
                    end else begin
                        r_state    <= ST_FETCH;
                        r_bus_a    <= MUX_PC;
                        r_mem_req  <= 1'b1;
                        r_busc_src <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_cond  <= uCONTROL_Registro_IR_InBUS[28:25];
                    r_setcc <= w_op3[4];
                    if (w_is_alu) begin
                        r_state <= ST_ALU;
                        r_bus_a <= src_code(w_rs1[1:0]);
                        r_bus_b <= w_i ? MUX_IR : src_code(w_rs2[1:0]);
                        // R0 is hardwired zero: never load it
                        r_bus_c <= (w_rd == 5'd0) ? LD_NONE : {4'b0000, w_rd[1:0]};
                        r_alu   <= alu_from_op3(w_op3[3:0]) | (w_i ? ALU_IMM_BIT : 4'b0000);
                    end else if (w_is_branch) begin
                        r_state <= ST_BRANCH_EVAL;
                    end else begin
                        r_state <= ST_HALT;
                        r_halt  <= 1'b1;
                    end
                end
                ST_ALU: begin
                    if (r_setcc) begin
                        r_psr <= ~{uCONTROL_negative_InLow, uCONTROL_zero_InLow,
                                   uCONTROL_overflow_InLow, uCONTROL_carry_InLow};
                    end
                    r_state <= ST_PCINC;
                    r_bus_a <= MUX_PC;
                    r_bus_c <= LD_PC;
                    r_alu   <= ALU_INC4_A;
                end
                ST_BRANCH_EVAL: begin
                    if (!w_legal) begin
                        r_state <= ST_HALT;
                        r_halt  <= 1'b1;
                    end else if (w_taken) begin
                        r_state <= ST_BRANCH;
                        r_bus_a <= MUX_PC;
                        r_bus_b <= MUX_IR;
                        r_bus_c <= LD_PC;
                        r_alu   <= ALU_BR_DISP;
                    end else begin
                        r_state <= ST_PCINC;
                        r_bus_a <= MUX_PC;
                        r_bus_c <= LD_PC;
                        r_alu   <= ALU_INC4_A;
                    end
                end
                ST_BRANCH, ST_PCINC: begin
                    r_state    <= ST_FETCH;
                    r_bus_a    <= MUX_PC;
                    r_mem_req  <= 1'b1;
                    r_busc_src <= 1'b1;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RST;
                end
            endcase
        end
    end

    // The IR load must coincide with the ack cycle itself, so the C code is
    // the only control that reacts to ack inside FETCH.
    assign uCONTROL_BUS_CONTROL_C_OutBUS =
        ((r_state == ST_FETCH) && uCONTROL_mem_ack_InHigh) ? LD_IR : r_bus_c;

    assign uCONTROL_BUS_CONTROL_A_OutBUS         = r_bus_a;
    assign uCONTROL_BUS_CONTROL_B_OutBUS         = r_bus_b;
    assign uCONTROL_BUS_SELECTOR_A_Out           = 1'b0;
    assign uCONTROL_BUS_SELECTOR_B_Out           = 1'b0;
    assign uCONTROL_BUS_SELECTOR_C_Out           = 1'b0;
    assign uCONTROL_decoderclearselection_OutBUS = CLR_IDLE;
    assign uCONTROL_aluselection_OutBUS          = r_alu;
    assign uCONTROL_mem_req_OutHigh              = r_mem_req;
    assign uCONTROL_busC_src_Out                 = r_busc_src;
    assign uCONTROL_psr_OutBUS                   = r_psr;
    assign uCONTROL_halt_OutHigh                 = r_halt;
    assign uCONTROL_state_OutBUS                 = r_state;

endmodule

// File: tb/tb_ucontrol_sequencer.sv
// Directed testbench for ucontrol_sequencer: each task drives one scenario
// and checks control outputs cycle by cycle against hand-computed values.
module tb_ucontrol_sequencer;
    import ucontrol_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir;
    logic        ovf_n, carry_n, neg_n, zero_n;
    logic        ack;
    logic        mem_req;
    logic        busc_src;
    logic [5:0]  bus_a, bus_b, bus_c;
    logic        sel_a, sel_b, sel_c;
    logic [3:0]  clr_sel;
    logic [3:0]  alu_sel;
    logic [3:0]  psr;
    logic        halt;
    logic [2:0]  st;

    int n_checks = 0;
    int n_fail   = 0;

    ucontrol_sequencer dut (
        .uCONTROL_CLOCK_50                     (clk),
        .uCONTROL_RESET_InLow                  (rst_n),
        .uCONTROL_Registro_IR_InBUS            (ir),
        .uCONTROL_overflow_InLow               (ovf_n),
        .uCONTROL_carry_InLow                  (carry_n),
        .uCONTROL_negative_InLow               (neg_n),
        .uCONTROL_zero_InLow                   (zero_n),
        .uCONTROL_mem_ack_InHigh               (ack),
        .uCONTROL_mem_req_OutHigh              (mem_req),
        .uCONTROL_busC_src_Out                 (busc_src),
        .uCONTROL_BUS_CONTROL_A_OutBUS         (bus_a),
        .uCONTROL_BUS_CONTROL_B_OutBUS         (bus_b),
        .uCONTROL_BUS_CONTROL_C_OutBUS         (bus_c),
        .uCONTROL_BUS_SELECTOR_A_Out           (sel_a),
        .uCONTROL_BUS_SELECTOR_B_Out           (sel_b),
        .uCONTROL_BUS_SELECTOR_C_Out           (sel_c),
        .uCONTROL_decoderclearselection_OutBUS (clr_sel),
        .uCONTROL_aluselection_OutBUS          (alu_sel),
        .uCONTROL_psr_OutBUS                   (psr),
        .uCONTROL_halt_OutHigh                 (halt),
        .uCONTROL_state_OutBUS                 (st)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample point is 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH cycle 1: wait n cycles, then ack with instr; ends in DECODE
    task automatic fetch_instr(input logic [31:0] instr, input int waits);
        repeat (waits) tick();
        ir  = instr;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ack = 1'b0; ir = 32'h0;
        ovf_n = 1'b1; carry_n = 1'b1; neg_n = 1'b1; zero_n = 1'b1;
        repeat (3) tick();
        n_checks++; if (st !== ST_RST) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", st, ST_RST); end
        n_checks++; if (bus_c !== 6'd15) begin n_fail++; $display("FAIL rst_bus_c: got %0d want 15", bus_c); end
        n_checks++; if (bus_a !== 6'd0 || bus_b !== 6'd0) begin n_fail++; $display("FAIL rst_bus_ab: got a=%0d b=%0d want 0 0", bus_a, bus_b); end
        n_checks++; if (alu_sel !== 4'd0) begin n_fail++; $display("FAIL rst_alu: got %0d want 0", alu_sel); end
        n_checks++; if (clr_sel !== 4'hF) begin n_fail++; $display("FAIL rst_clear: got %h want f", clr_sel); end
        n_checks++; if (mem_req !== 1'b0 || busc_src !== 1'b0) begin n_fail++; $display("FAIL rst_req_src: got req=%b src=%b want 0 0", mem_req, busc_src); end
        n_checks++; if (psr !== 4'd0 || halt !== 1'b0) begin n_fail++; $display("FAIL rst_psr_halt: got psr=%b halt=%b want 0000 0", psr, halt); end
        n_checks++; if ({sel_a, sel_b, sel_c} !== 3'b000) begin n_fail++; $display("FAIL rst_selectors: got %b want 000", {sel_a, sel_b, sel_c}); end
        rst_n = 1'b1;
        n_checks++; if (st !== ST_RST) begin n_fail++; $display("FAIL rst_release_state: got %0d want %0d", st, ST_RST); end
        tick();
    endtask

    // ADD r1 <- r1 + r3 (32'h82004003), ack on the 3rd FETCH cycle
    task automatic test_alu_add();
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (mem_req !== 1'b1 || st !== ST_FETCH) begin n_fail++; $display("FAIL add_fetch_wait%0d: got req=%b st=%0d want 1 %0d", c, mem_req, st, ST_FETCH); end
            n_checks++; if (bus_a !== 6'd6 || bus_c !== 6'd15 || busc_src !== 1'b1) begin n_fail++; $display("FAIL add_fetch_ctl%0d: got a=%0d c=%0d src=%b want 6 15 1", c, bus_a, bus_c, busc_src); end
            tick();
        end
        ir = 32'h82004003;
        ack = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b1 || bus_c !== 6'd6) begin n_fail++; $display("FAIL add_ack_cycle: got req=%b c=%0d want 1 6", mem_req, bus_c); end
        tick();
        ack = 1'b0;
        n_checks++; if (st !== ST_DECODE || mem_req !== 1'b0) begin n_fail++; $display("FAIL add_decode: got st=%0d req=%b want %0d 0", st, mem_req, ST_DECODE); end
        tick();
        n_checks++; if (st !== ST_ALU) begin n_fail++; $display("FAIL add_alu_state: got %0d want %0d", st, ST_ALU); end
        n_checks++; if (bus_a !== 6'd2 || bus_b !== 6'd4 || bus_c !== 6'd1) begin n_fail++; $display("FAIL add_alu_buses: got a=%0d b=%0d c=%0d want 2 4 1", bus_a, bus_b, bus_c); end
        n_checks++; if (alu_sel !== 4'd0 || busc_src !== 1'b0) begin n_fail++; $display("FAIL add_alu_sel: got alu=%0d src=%b want 0 0", alu_sel, busc_src); end
        tick();
        n_checks++; if (st !== ST_PCINC || alu_sel !== 4'd6 || bus_c !== 6'd5 || bus_a !== 6'd6) begin n_fail++; $display("FAIL add_pcinc: got st=%0d alu=%0d c=%0d a=%0d want %0d 6 5 6", st, alu_sel, bus_c, bus_a, ST_PCINC); end
        tick();
        n_checks++; if (st !== ST_FETCH || mem_req !== 1'b1) begin n_fail++; $display("FAIL add_refetch: got st=%0d req=%b want %0d 1", st, mem_req, ST_FETCH); end
    endtask

    // SUBcc r1,r1,r1 (32'h82A04001) with zero flag asserted; then plain ADD keeps psr
    task automatic test_psr();
        zero_n = 1'b0;
        fetch_instr(32'h82A04001, 0);
        tick();
        n_checks++; if (alu_sel !== 4'd1) begin n_fail++; $display("FAIL subcc_alu: got %0d want 1", alu_sel); end
        n_checks++; if (psr !== 4'b0000) begin n_fail++; $display("FAIL subcc_psr_before: got %b want 0000", psr); end
        tick();
        n_checks++; if (psr !== 4'b0100) begin n_fail++; $display("FAIL subcc_psr: got %b want 0100", psr); end
        tick();
        ovf_n = 1'b0; carry_n = 1'b0; neg_n = 1'b0; zero_n = 1'b0;
        fetch_instr(32'h82004003, 1);
        tick();
        tick();
        n_checks++; if (psr !== 4'b0100) begin n_fail++; $display("FAIL add_psr_hold: got %b want 0100", psr); end
        tick();
        ovf_n = 1'b1; carry_n = 1'b1; neg_n = 1'b1; zero_n = 1'b1;
    endtask

    // BE taken (z=1), clear z, BE not taken, then BNE taken
    task automatic test_branch();
        fetch_instr(32'h02800004, 0);
        n_checks++; if (st !== ST_DECODE) begin n_fail++; $display("FAIL be_decode: got %0d want %0d", st, ST_DECODE); end
        tick();
        n_checks++; if (st !== ST_BRANCH_EVAL) begin n_fail++; $display("FAIL be_eval: got %0d want %0d", st, ST_BRANCH_EVAL); end
        tick();
        n_checks++; if (st !== ST_BRANCH) begin n_fail++; $display("FAIL be_taken_state: got %0d want %0d", st, ST_BRANCH); end
        n_checks++; if (bus_a !== 6'd6 || bus_b !== 6'd7 || alu_sel !== 4'd7 || bus_c !== 6'd5) begin n_fail++; $display("FAIL be_taken_ctl: got a=%0d b=%0d alu=%0d c=%0d want 6 7 7 5", bus_a, bus_b, alu_sel, bus_c); end
        tick();
        n_checks++; if (st !== ST_FETCH) begin n_fail++; $display("FAIL be_skip_pcinc: got %0d want %0d", st, ST_FETCH); end
        fetch_instr(32'h82A04001, 0);
        tick();
        tick();
        n_checks++; if (psr !== 4'b0000) begin n_fail++; $display("FAIL clear_z_psr: got %b want 0000", psr); end
        tick();
        fetch_instr(32'h02800004, 2);
        tick();
        tick();
        n_checks++; if (st !== ST_PCINC || alu_sel !== 4'd6 || bus_c !== 6'd5) begin n_fail++; $display("FAIL be_not_taken: got st=%0d alu=%0d c=%0d want %0d 6 5", st, alu_sel, bus_c, ST_PCINC); end
        tick();
        fetch_instr(32'h12800004, 0);
        tick();
        tick();
        n_checks++; if (st !== ST_BRANCH) begin n_fail++; $display("FAIL bne_taken: got %0d want %0d", st, ST_BRANCH); end
        tick();
    endtask

    // ADD r0,r1,r2 (32'h80004002): destination R0 must never load
    task automatic test_rd_zero();
        fetch_instr(32'h80004002, 0);
        tick();
        n_checks++; if (bus_c !== 6'd15 || bus_a !== 6'd2 || bus_b !== 6'd3) begin n_fail++; $display("FAIL rd0: got c=%0d a=%0d b=%0d want 15 2 3", bus_c, bus_a, bus_b); end
        tick();
        tick();
    endtask

    // ADD r1,r2,-1 (32'h8200BFFF): immediate form
    task automatic test_imm();
        fetch_instr(32'h8200BFFF, 1);
        tick();
        n_checks++; if (alu_sel !== 4'b1000 || bus_b !== 6'd7) begin n_fail++; $display("FAIL imm_alu_b: got alu=%b b=%0d want 1000 7", alu_sel, bus_b); end
        n_checks++; if (bus_a !== 6'd3 || bus_c !== 6'd1 || st !== ST_ALU) begin n_fail++; $display("FAIL imm_a_c: got a=%0d c=%0d st=%0d want 3 1 %0d", bus_a, bus_c, st, ST_ALU); end
        tick();
        tick();
    endtask

    // ADD r1,r5,r2 (32'h82014002): out-of-range rs1 halts, sticky
    task automatic test_halt();
        fetch_instr(32'h82014002, 0);
        tick();
        n_checks++; if (st !== ST_HALT || halt !== 1'b1) begin n_fail++; $display("FAIL halt_enter: got st=%0d halt=%b want %0d 1", st, halt, ST_HALT); end
        n_checks++; if (mem_req !== 1'b0 || bus_c !== 6'd15) begin n_fail++; $display("FAIL halt_ctl: got req=%b c=%0d want 0 15", mem_req, bus_c); end
        ack = 1'b1;
        repeat (3) tick();
        ack = 1'b0;
        #1;
        n_checks++; if (halt !== 1'b1 || st !== ST_HALT || mem_req !== 1'b0) begin n_fail++; $display("FAIL halt_sticky: got halt=%b st=%0d req=%b want 1 %0d 0", halt, st, mem_req, ST_HALT); end
    endtask

    // Reset out of HALT, then reset mid-fetch with a stray ack during RST
    task automatic test_reset_mid_fetch();
        rst_n = 1'b0;
        #1;
        n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_clears_halt: got %b want 0", halt); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (st !== ST_FETCH || mem_req !== 1'b1) begin n_fail++; $display("FAIL refetch_after_reset: got st=%0d req=%b want %0d 1", st, mem_req, ST_FETCH); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || st !== ST_RST) begin n_fail++; $display("FAIL async_req_clear: got req=%b st=%0d want 0 %0d", mem_req, st, ST_RST); end
        ack = 1'b1;
        ir  = 32'h82004003;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (st !== ST_RST || bus_c !== 6'd15) begin n_fail++; $display("FAIL stray_ack_rst: got st=%0d c=%0d want %0d 15", st, bus_c, ST_RST); end
        tick();
        ack = 1'b0;
        #1;
        n_checks++; if (st !== ST_FETCH || mem_req !== 1'b1 || bus_c !== 6'd15) begin n_fail++; $display("FAIL stray_ack_ignored: got st=%0d req=%b c=%0d want %0d 1 15", st, mem_req, bus_c, ST_FETCH); end
    endtask

    // Bicc with unsupported cond 0000 (32'h00800000) halts from BRANCH_EVAL
    task automatic test_bad_cond();
        fetch_instr(32'h00800000, 0);
        tick();
        n_checks++; if (st !== ST_BRANCH_EVAL) begin n_fail++; $display("FAIL badcond_eval: got %0d want %0d", st, ST_BRANCH_EVAL); end
        tick();
        n_checks++; if (st !== ST_HALT || halt !== 1'b1) begin n_fail++; $display("FAIL badcond_halt: got st=%0d halt=%b want %0d 1", st, halt, ST_HALT); end
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_psr();
        test_branch();
        test_rd_zero();
        test_imm();
        test_halt();
        test_reset_mid_fetch();
        test_bad_cond();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
